circular_buffer_vw: RTL and testbench
=====================================

Name: circular_buffer_vw

Overview:
Next-generation PE scratchpad circular FIFO. Accepts a variable number of elements per cycle on the write side (0..W_PARAM) and releases a variable number on the read side (0..R_PARAM). Presents a show-ahead window of the oldest R_PARAM entries. Adds an occupancy count and a synchronous clear. Sits between the GLB feed and the PE MAC datapath, for ifmap, filter and psum streams.

Parameters:
DATA_WIDTH, 8, element width in bits
BUFFER_SIZE, 16, capacity in elements; any value >= max(W_PARAM, R_PARAM); power of two not required
W_PARAM, 4, max elements written per cycle
R_PARAM, 4, max elements read per cycle
(derived localparams) PTR_W = $clog2(BUFFER_SIZE), CNT_W = $clog2(BUFFER_SIZE+1), WC_W = $clog2(W_PARAM+1), RC_W = $clog2(R_PARAM+1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; asynchronous assert, active-low (rst==0 resets)
clear  in  1  synchronous flush
write_en  in  1  write request
write_cnt  in  WC_W  number of elements to write this cycle
inp  in  DATA_WIDTH*W_PARAM  lane 0 = LSBs = oldest element of the group
read_en  in  1  read/pop request
read_cnt  in  RC_W  number of elements to pop this cycle
data_out  out  DATA_WIDTH*R_PARAM  show-ahead window; lane 0 = oldest entry
count  out  CNT_W  current occupancy
full  out  1  count == BUFFER_SIZE
empty  out  1  count == 0
ready  out  1  free space >= write_cnt (combinational)
valid  out  1  count >= read_cnt (combinational)

Behaviour:
- Reset (rst==0, async): wr_ptr=0, rd_ptr=0, count=0. Outputs: empty=1, full=0, ready=1, valid=(read_cnt==0), data_out=0. Storage contents are not reset.
- Definitions: free = BUFFER_SIZE - count. All acceptance decisions use start-of-cycle count.
- Write acceptance: accepted iff write_en && write_cnt<=free && write_cnt<=W_PARAM.
  - On accept: lane i (i<write_cnt) is stored at (wr_ptr+i) mod BUFFER_SIZE.
  - wr_ptr advances by write_cnt, mod BUFFER_SIZE.
  - A rejected write changes no state.
- Read acceptance: accepted iff read_en && read_cnt<=count && read_cnt<=R_PARAM.
  - On accept: rd_ptr advances by read_cnt, mod BUFFER_SIZE.
  - A rejected read changes no state.
- Zero counts: write_cnt=0 or read_cnt=0 is a legal no-op.
- Simultaneous read and write: each is evaluated independently against the start-of-cycle count. count_next = count + accepted_wc - accepted_rc. A read does not create space for a same-cycle write; a write does not feed a same-cycle read.
- data_out (combinational from registers, zero latency):
  - lane i = mem[(rd_ptr+i) mod BUFFER_SIZE] for i<count.
  - lane i = 0 for i>=count.
- Write-to-read latency: 1 cycle. Data written at edge N is visible on data_out after edge N.
- clear: has priority over write and read in the same cycle. Sets wr_ptr=rd_ptr=count=0 at the next edge. If asserted mid-burst, the in-flight write is discarded.
- Wrap: pointer add uses a compare-and-subtract (sum >= BUFFER_SIZE ? sum-BUFFER_SIZE : sum), never a bit truncation, so non-power-of-two sizes are correct.

Optional Feature:
Macro CIRC_BUF_ERR_EN.
- Defined: adds outputs err_ovf and err_udf, each 1 bit.
  - err_ovf sets on write_en && write_cnt>free.
  - err_udf sets on read_en && read_cnt>count.
  - Both are sticky; cleared by rst or clear.
- Undefined: these ports and their logic are absent. Illegal requests are silently dropped.

Decomposition:
- Package circ_buf_pkg holds:
  - width helper functions (ptr/count widths);
  - the modular-add function wrap_add(ptr, inc, size);
  - reset constants for pointers and count.
- Sub-module circ_buf_ptr_ctrl owns wr_ptr, rd_ptr, count, the accept logic, and full/empty/ready/valid.
- The storage array and read-window mux stay in the top module.

Test Plan:
- Reset: drive rst=0 mid-traffic with read_cnt=1 -> same cycle count=0, empty=1, full=0, ready=1, valid=0, data_out=0.
- Fill: 4 cycles of write_cnt=4, values 0x01..0x10 -> count=16, full=1, ready=0; a fifth write of 4 is dropped and count stays 16.
- Variable mix: write {0xA0,0xA1,0xA2} (cnt=3), then read_cnt=2 -> window shows A0,A1,A2,0x00 before the pop; after the pop count=1, lane0=0xA2, lanes1-3=0.
- Wrap: write 14, read 12, then write 4 {0xB0..0xB3} -> stored at indices 14,15,0,1; count=6; reading 6 returns 0x0D,0x0E,B0,B1,B2,B3 in order.
- Full simultaneous: count=16, write_cnt=4 and read_cnt=4 in the same cycle -> write rejected, read accepted, count=12.
- Clear/error (with CIRC_BUF_ERR_EN): read_cnt=3 at count=2 -> err_udf=1, count stays 2; clear together with write_cnt=4 -> count=0, empty=1, err_udf=0.

Source files
------------

// File: rtl/circular_buffer_vw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : circ_buf_pkg
// Description : Shared width helpers, modular pointer add and reset values for
//               the variable-width circular buffer.
// Options     : CIRC_BUF_ERR_EN (sticky overflow/underflow flags, see top)
// Revision    : 1.0 - initial release
// ============================================================================
package circ_buf_pkg;

  localparam int unsigned PTR_RST_VAL = 0;
  localparam int unsigned CNT_RST_VAL = 0;

  // Pointer width; a single-entry buffer still gets one bit of pointer.
  function automatic int unsigned ptr_width(input int unsigned size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  // Width able to hold the values 0..max inclusive.
  function automatic int unsigned cnt_width(input int unsigned max);
    return $clog2(max + 1);
  endfunction

  // Modular add for ptr < size and inc <= size. Compare-and-subtract keeps
  // non power-of-two sizes correct where bit truncation would not.
  function automatic int unsigned wrap_add(input int unsigned ptr,
                                           input int unsigned inc,
                                           input int unsigned size);
    int unsigned sum;
    sum = ptr + inc;
    return (sum >= size) ? (sum - size) : sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/circular_buffer_vw_if.sv
`default_nettype none
// ============================================================================
// Module      : circular_buffer_vw_if
// Description : Write/read request bundle and status outputs of the
//               variable-width circular buffer.
// Options     : CIRC_BUF_ERR_EN adds err_ovf / err_udf
// Revision    : 1.0 - initial release
// ============================================================================
interface circular_buffer_vw_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int BUFFER_SIZE = 16,
  parameter int W_PARAM     = 4,
  parameter int R_PARAM     = 4
);
  import circ_buf_pkg::*;

  localparam int CNT_W = cnt_width(BUFFER_SIZE);
  localparam int WC_W  = cnt_width(W_PARAM);
  localparam int RC_W  = cnt_width(R_PARAM);

  logic                          clear;
  logic                          write_en;
  logic [WC_W-1:0]               write_cnt;
  logic [DATA_WIDTH*W_PARAM-1:0] inp;
  logic                          read_en;
  logic [RC_W-1:0]               read_cnt;
  logic [DATA_WIDTH*R_PARAM-1:0] data_out;
  logic [CNT_W-1:0]              count;
  logic                          full;
  logic                          empty;
  logic                          ready;
  logic                          valid;
`ifdef CIRC_BUF_ERR_EN
  logic                          err_ovf;
  logic                          err_udf;
`endif

  modport master (
    output clear, write_en, write_cnt, inp, read_en, read_cnt,
    input  data_out, count, full, empty, ready, valid
`ifdef CIRC_BUF_ERR_EN
    , input err_ovf, err_udf
`endif
  );

  modport slave (
    input  clear, write_en, write_cnt, inp, read_en, read_cnt,
    output data_out, count, full, empty, ready, valid
`ifdef CIRC_BUF_ERR_EN
    , output err_ovf, err_udf
`endif
  );

endinterface
`default_nettype wire

// File: rtl/circular_buffer_vw_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : circ_buf_ptr_ctrl
// Description : Write/read pointers, occupancy, accept logic and status flags
//               of the variable-width circular buffer.
// Options     : CIRC_BUF_ERR_EN adds sticky err_ovf / err_udf
// Revision    : 1.0 - initial release
// ============================================================================
module circ_buf_ptr_ctrl
  import circ_buf_pkg::*;
#(
  parameter  int BUFFER_SIZE = 16,
  parameter  int W_PARAM     = 4,
  parameter  int R_PARAM     = 4,
  localparam int PTR_W       = ptr_width(BUFFER_SIZE),
  localparam int CNT_W       = cnt_width(BUFFER_SIZE),
  localparam int WC_W        = cnt_width(W_PARAM),
  localparam int RC_W        = cnt_width(R_PARAM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             write_en,
  input  logic [WC_W-1:0]  write_cnt,
  input  logic             read_en,
  input  logic [RC_W-1:0]  read_cnt,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             wr_fire,
  output logic             full,
  output logic             empty,
  output logic             ready,
  output logic             valid
`ifdef CIRC_BUF_ERR_EN
  ,
  output logic             err_ovf,
  output logic             err_udf
`endif
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      free;
  logic [31:0]      wc_acc;
  logic [31:0]      rc_acc;
  logic             wr_acc;
  logic             rd_acc;

  // Accept decisions, both judged against the start-of-cycle occupancy
  always_comb begin
    free   = 32'(BUFFER_SIZE) - 32'(count_q);
    wr_acc = write_en && (32'(write_cnt) <= free) && (32'(write_cnt) <= 32'(W_PARAM));
    rd_acc = read_en && (32'(read_cnt) <= 32'(count_q)) && (32'(read_cnt) <= 32'(R_PARAM));
    wc_acc = wr_acc ? 32'(write_cnt) : 32'd0;
    rc_acc = rd_acc ? 32'(read_cnt) : 32'd0;
  end

  // Next pointers and occupancy; clear overrides any same-cycle traffic
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = PTR_W'(PTR_RST_VAL);
      rd_ptr_d = PTR_W'(PTR_RST_VAL);
      count_d  = CNT_W'(CNT_RST_VAL);
    end else begin
      wr_ptr_d = PTR_W'(wrap_add(32'(wr_ptr_q), wc_acc, BUFFER_SIZE));
      rd_ptr_d = PTR_W'(wrap_add(32'(rd_ptr_q), rc_acc, BUFFER_SIZE));
      count_d  = CNT_W'(32'(count_q) + wc_acc - rc_acc);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= PTR_W'(PTR_RST_VAL);
      rd_ptr_q <= PTR_W'(PTR_RST_VAL);
      count_q  <= CNT_W'(CNT_RST_VAL);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr  = wr_ptr_q;
  assign rd_ptr  = rd_ptr_q;
  assign count   = count_q;
  assign wr_fire = wr_acc && !clear;
  assign full    = (count_q == CNT_W'(BUFFER_SIZE));
  assign empty   = (count_q == '0);
  assign ready   = (free >= 32'(write_cnt));
  assign valid   = (32'(count_q) >= 32'(read_cnt));

`ifdef CIRC_BUF_ERR_EN
  logic err_ovf_q, err_ovf_d;
  logic err_udf_q, err_udf_d;

  // Sticky error capture, dropped by clear
  always_comb begin
    err_ovf_d = err_ovf_q || (write_en && (32'(write_cnt) > free));
    err_udf_d = err_udf_q || (read_en && (32'(read_cnt) > 32'(count_q)));
    if (clear) begin
      err_ovf_d = 1'b0;
      err_udf_d = 1'b0;
    end
  end

  // Error flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`endif

endmodule
`default_nettype wire

// File: rtl/circular_buffer_vw.sv
`default_nettype none
// ============================================================================
// Module      : circular_buffer_vw
// Description : Circular FIFO taking 0..W_PARAM elements per cycle and popping
//               0..R_PARAM, with a show-ahead window of the oldest R_PARAM.
// Options     : `define CIRC_BUF_ERR_EN for sticky err_ovf / err_udf outputs
// Revision    : 1.0 - initial release
// ============================================================================
module circular_buffer_vw
  import circ_buf_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int BUFFER_SIZE = 16,
  parameter int W_PARAM     = 4,
  parameter int R_PARAM     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  circular_buffer_vw_if.slave  bus
);

  localparam int PTR_W = ptr_width(BUFFER_SIZE);
  localparam int CNT_W = cnt_width(BUFFER_SIZE);

  logic [PTR_W-1:0]              wr_ptr;
  logic [PTR_W-1:0]              rd_ptr;
  logic [CNT_W-1:0]              count;
  logic                          wr_fire;
  logic [DATA_WIDTH-1:0]         mem_q [BUFFER_SIZE];
  logic [W_PARAM-1:0]            lane_we;
  logic [PTR_W-1:0]              lane_addr [W_PARAM];
  logic [DATA_WIDTH*R_PARAM-1:0] window;

  circ_buf_ptr_ctrl #(
    .BUFFER_SIZE (BUFFER_SIZE),
    .W_PARAM     (W_PARAM),
    .R_PARAM     (R_PARAM)
  ) u_ptr_ctrl (
    .clk       (clk),
    .rst       (rst),
    .clear     (bus.clear),
    .write_en  (bus.write_en),
    .write_cnt (bus.write_cnt),
    .read_en   (bus.read_en),
    .read_cnt  (bus.read_cnt),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .wr_fire   (wr_fire),
    .full      (bus.full),
    .empty     (bus.empty),
    .ready     (bus.ready),
    .valid     (bus.valid)
`ifdef CIRC_BUF_ERR_EN
    ,
    .err_ovf   (bus.err_ovf),
    .err_udf   (bus.err_udf)
`endif
  );

  // Per-lane write enable and wrapped storage address for an accepted group
  always_comb begin
    for (int i = 0; i < W_PARAM; i++) begin
      lane_we[i]   = wr_fire && (32'(bus.write_cnt) > 32'(i));
      lane_addr[i] = PTR_W'(wrap_add(32'(wr_ptr), 32'(i), BUFFER_SIZE));
    end
  end

  // Storage array; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    for (int i = 0; i < W_PARAM; i++) begin
      if (lane_we[i]) begin
        mem_q[lane_addr[i]] <= bus.inp[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Show-ahead window: oldest entries first, lanes beyond occupancy read zero
  always_comb begin
    window = '0;
    for (int i = 0; i < R_PARAM; i++) begin
      if (32'(count) > 32'(i)) begin
        window[i*DATA_WIDTH +: DATA_WIDTH] =
          mem_q[PTR_W'(wrap_add(32'(rd_ptr), 32'(i), BUFFER_SIZE))];
      end
    end
  end

  assign bus.data_out = window;
  assign bus.count    = count;

endmodule
`default_nettype wire

// File: tb/tb_circular_buffer_vw.sv
`default_nettype none
// ============================================================================
// Module      : tb_circular_buffer_vw
// Description : Directed self-checking bench for circular_buffer_vw.
// Options     : CIRC_BUF_ERR_EN enables the error-flag checks
// Revision    : 1.0 - initial release
// ============================================================================
module tb_circular_buffer_vw;
  import circ_buf_pkg::*;

  localparam int DATA_WIDTH  = 8;
  localparam int BUFFER_SIZE = 16;
  localparam int W_PARAM     = 4;
  localparam int R_PARAM     = 4;
  localparam int WC_W        = cnt_width(W_PARAM);
  localparam int RC_W        = cnt_width(R_PARAM);

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  circular_buffer_vw_if #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BUFFER_SIZE (BUFFER_SIZE),
    .W_PARAM     (W_PARAM),
    .R_PARAM     (R_PARAM)
  ) bus ();

  circular_buffer_vw #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BUFFER_SIZE (BUFFER_SIZE),
    .W_PARAM     (W_PARAM),
    .R_PARAM     (R_PARAM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic we, input int wc, input logic [31:0] d,
                        input logic re, input int rc);
    bus.write_en  = we;
    bus.write_cnt = WC_W'(wc);
    bus.inp       = d;
    bus.read_en   = re;
    bus.read_cnt  = RC_W'(rc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    bus.clear    = 1'b0;
  endtask

  // Group k of the incrementing pattern: lane j holds 4k+j+1
  function automatic logic [31:0] seq_group(input int k);
    logic [31:0] d;
    for (int j = 0; j < 4; j++) d[j*8 +: 8] = 8'(4*k + j + 1);
    return d;
  endfunction

  initial begin
    rst = 1'b0;
    bus.clear = 1'b0;
    set_in(1'b0, 0, 32'h0, 1'b0, 0);
    #2;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full",  32'(bus.full),  32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_valid_rc0", 32'(bus.valid), 32'd1);
    check("rst_data", bus.data_out, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Fill with 0x01..0x10
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 4, seq_group(k), 1'b0, 0);
      tick();
    end
    check("fill_count", 32'(bus.count), 32'd16);
    check("fill_full",  32'(bus.full),  32'd1);
    check("fill_data",  bus.data_out,   32'h04030201);
    set_in(1'b1, 4, 32'hDEADBEEF, 1'b0, 0);
    #1;
    check("fill_ready", 32'(bus.ready), 32'd0);
    tick();
    check("fill_drop_count", 32'(bus.count), 32'd16);
`ifdef CIRC_BUF_ERR_EN
    check("fill_err_ovf", 32'(bus.err_ovf), 32'd1);
`endif

    // Full with simultaneous write and read: only the read lands
    set_in(1'b1, 4, 32'h55555555, 1'b1, 4);
    tick();
    check("sim_count", 32'(bus.count), 32'd12);
    check("sim_full",  32'(bus.full),  32'd0);
    check("sim_data",  bus.data_out,   32'h08070605);

    // Drain
    repeat (3) begin
      set_in(1'b0, 0, 32'h0, 1'b1, 4);
      tick();
    end
    check("drain_count", 32'(bus.count), 32'd0);
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_data",  bus.data_out,   32'h0);

    // Zero-count requests are no-ops
    set_in(1'b1, 0, 32'hFFFFFFFF, 1'b1, 0);
    tick();
    check("zero_count", 32'(bus.count), 32'd0);

    // Variable mix: write three, pop two
    set_in(1'b1, 3, 32'hEEA2A1A0, 1'b0, 0);
    tick();
    check("mix_count3", 32'(bus.count), 32'd3);
    set_in(1'b0, 0, 32'h0, 1'b1, 2);
    #1;
    check("mix_window", bus.data_out, 32'h00A2A1A0);
    tick();
    check("mix_count1", 32'(bus.count), 32'd1);
    check("mix_after",  bus.data_out,   32'h000000A2);

    // Clear beats a same-cycle write
    set_in(1'b1, 4, 32'h11223344, 1'b0, 0);
    bus.clear = 1'b1;
    tick();
    check("clr_count", 32'(bus.count), 32'd0);
    check("clr_empty", 32'(bus.empty), 32'd1);
    check("clr_data",  bus.data_out,   32'h0);
`ifdef CIRC_BUF_ERR_EN
    check("clr_err_ovf", 32'(bus.err_ovf), 32'd0);
`endif

    // Wrap: 14 in, 12 out, then 4 more landing at 14,15,0,1
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, (k < 3) ? 4 : 2, seq_group(k), 1'b0, 0);
      tick();
    end
    check("wrap_count14", 32'(bus.count), 32'd14);
    repeat (3) begin
      set_in(1'b0, 0, 32'h0, 1'b1, 4);
      tick();
    end
    check("wrap_count2", 32'(bus.count), 32'd2);
    check("wrap_data2",  bus.data_out,   32'h00000E0D);
    set_in(1'b1, 4, 32'hB3B2B1B0, 1'b0, 0);
    tick();
    check("wrap_count6", 32'(bus.count), 32'd6);
    check("wrap_data6",  bus.data_out,   32'hB1B00E0D);
    set_in(1'b0, 0, 32'h0, 1'b1, 4);
    tick();
    check("wrap_pop_count", 32'(bus.count), 32'd2);
    check("wrap_pop_data",  bus.data_out,   32'h0000B3B2);

    // Underflow request is dropped
    set_in(1'b0, 0, 32'h0, 1'b1, 3);
    #1;
    check("udf_valid", 32'(bus.valid), 32'd0);
    tick();
    check("udf_count", 32'(bus.count), 32'd2);
`ifdef CIRC_BUF_ERR_EN
    check("udf_err", 32'(bus.err_udf), 32'd1);
`endif
    set_in(1'b1, 4, 32'hCAFEF00D, 1'b0, 0);
    bus.clear = 1'b1;
    tick();
    check("udf_clr_count", 32'(bus.count), 32'd0);
    check("udf_clr_empty", 32'(bus.empty), 32'd1);
`ifdef CIRC_BUF_ERR_EN
    check("udf_clr_err", 32'(bus.err_udf), 32'd0);
`endif

    // Asynchronous reset in the middle of traffic
    set_in(1'b1, 3, 32'h00C2C1C0, 1'b0, 0);
    tick();
    check("pre_rst_count", 32'(bus.count), 32'd3);
    set_in(1'b1, 4, 32'h77777777, 1'b1, 1);
    #3;
    rst = 1'b0;
    #1;
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_empty", 32'(bus.empty), 32'd1);
    check("arst_full",  32'(bus.full),  32'd0);
    check("arst_ready", 32'(bus.ready), 32'd1);
    check("arst_valid", 32'(bus.valid), 32'd0);
    check("arst_data",  bus.data_out,   32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
